// File: rtl/dot8_pkg.sv
// Shared constants and lane mapping for the 8-lane dot-product path.
// Used by dot8_packer and by the engine that consumes its vectors.
package dot8_pkg;

    localparam int DOT8_LANES = 8;

    // Width of the populated-lane count (1..8 needs 4 bits).
    localparam int OLANES_W = 4;

    // Bit offset of a lane inside a packed vector; lane 0 is the LSB.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dot8_packer.sv
// Serial-to-parallel packer feeding the 8-lane dot-product engine.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   ivalid          element pair valid (no ready; always accepted)
//   ia, ib          signed elements for vec0 / vec1
//   ilast           element closes the current dot product
//   vec0, vec1      packed vectors, lane k at [k*IWIDTH +: IWIDTH]
//   ovalid          one-cycle pulse per emitted vector
//   olast           emitted vector closes a dot product
//   olanes          populated lanes in the emitted vector (1..8)
//   ovec_idx        index of the vector within its dot product
module dot8_packer
    import dot8_pkg::*;
#(
    parameter int IWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ivalid,
    input  logic [IWIDTH-1:0]            ia,
    input  logic [IWIDTH-1:0]            ib,
    input  logic                         ilast,
    output logic [DOT8_LANES*IWIDTH-1:0] vec0,
    output logic [DOT8_LANES*IWIDTH-1:0] vec1,
    output logic                         ovalid,
    output logic                         olast,
    output logic [OLANES_W-1:0]          olanes,
    output logic [CWIDTH-1:0]            ovec_idx
);

    localparam int VW = DOT8_LANES * IWIDTH;
    localparam logic [CWIDTH-1:0] IDX_ONE = 1;

    logic [2:0]        cnt;
    logic [CWIDTH-1:0] idx;
    logic [IWIDTH-1:0] stg_a [0:DOT8_LANES-2];
    logic [IWIDTH-1:0] stg_b [0:DOT8_LANES-2];

    logic          emit;
    logic [VW-1:0] nv0;
    logic [VW-1:0] nv1;

    assign emit = ivalid && ((cnt == 3'd7) || ilast);

    // Lanes below cnt come from staging, lane cnt takes the incoming
    // element, everything above stays zero so stale staging never leaks.
    always_comb begin
        nv0 = '0;
        nv1 = '0;
        for (int k = 0; k < DOT8_LANES - 1; k++) begin
            if (3'(k) < cnt) begin
                nv0[lane_lo(k, IWIDTH) +: IWIDTH] = stg_a[k];
                nv1[lane_lo(k, IWIDTH) +: IWIDTH] = stg_b[k];
            end
        end
        for (int k = 0; k < DOT8_LANES; k++) begin
            if (3'(k) == cnt) begin
                nv0[lane_lo(k, IWIDTH) +: IWIDTH] = ia;
                nv1[lane_lo(k, IWIDTH) +: IWIDTH] = ib;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            vec0     <= '0;
            vec1     <= '0;
            ovalid   <= 1'b0;
            olast    <= 1'b0;
            olanes   <= '0;
            ovec_idx <= '0;
            for (int k = 0; k < DOT8_LANES - 1; k++) begin
                stg_a[k] <= '0;
                stg_b[k] <= '0;
            end
        end else begin
            ovalid <= emit;
            if (emit) begin
                cnt      <= '0;
                vec0     <= nv0;
                vec1     <= nv1;
                olast    <= ilast;
                olanes   <= OLANES_W'(cnt) + OLANES_W'(1);
                ovec_idx <= idx;
                idx      <= ilast ? '0 : idx + IDX_ONE;
            end else if (ivalid) begin
                cnt <= cnt + 3'd1;
                for (int k = 0; k < DOT8_LANES - 1; k++) begin
                    if (cnt == 3'(k)) begin
                        stg_a[k] <= ia;
                        stg_b[k] <= ib;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dot8_packer.sv
// Self-checking bench for dot8_packer with a queue-based reference.
// A second instance with CWIDTH=2 shares the stimulus to check wrap.
module tb_dot8_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivalid;
    logic [7:0]  ia;
    logic [7:0]  ib;
    logic        ilast;
    logic [63:0] vec0;
    logic [63:0] vec1;
    logic        ovalid;
    logic        olast;
    logic [3:0]  olanes;
    logic [15:0] ovec_idx;
    logic [63:0] w_vec0;
    logic [63:0] w_vec1;
    logic        w_ovalid;
    logic        w_olast;
    logic [3:0]  w_olanes;
    logic [1:0]  w_idx;

    int checks = 0;
    int failures = 0;

    // Reference state: pending elements of the current vector,
    // vector index in the current dot product, expected outputs.
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    int          vidx;
    bit          pend;
    logic [63:0] e_v0;
    logic [63:0] e_v1;
    logic [3:0]  e_lanes;
    logic        e_last;
    logic [15:0] e_idx;
    logic [1:0]  e_widx;

    dot8_packer #(.IWIDTH(8), .CWIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .ivalid(ivalid), .ia(ia), .ib(ib),
        .ilast(ilast), .vec0(vec0), .vec1(vec1), .ovalid(ovalid),
        .olast(olast), .olanes(olanes), .ovec_idx(ovec_idx)
    );

    dot8_packer #(.IWIDTH(8), .CWIDTH(2)) u_wrap (
        .clk(clk), .rst(rst), .ivalid(ivalid), .ia(ia), .ib(ib),
        .ilast(ilast), .vec0(w_vec0), .vec1(w_vec1),
        .ovalid(w_ovalid), .olast(w_olast), .olanes(w_olanes),
        .ovec_idx(w_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [7:0] q[$]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++) r[i*8 +: 8] = q[i];
        return r;
    endfunction

    task automatic compare();
        chk("ovalid", 64'(ovalid), 64'(pend));
        chk("w_ovalid", 64'(w_ovalid), 64'(pend));
        chk("vec0", vec0, e_v0);
        chk("vec1", vec1, e_v1);
        chk("olanes", 64'(olanes), 64'(e_lanes));
        chk("olast", 64'(olast), 64'(e_last));
        chk("ovec_idx", 64'(ovec_idx), 64'(e_idx));
        chk("wrap_idx", 64'(w_idx), 64'(e_widx));
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        vidx    = 0;
        pend    = 0;
        e_v0    = '0;
        e_v1    = '0;
        e_lanes = '0;
        e_last  = 1'b0;
        e_idx   = '0;
        e_widx  = '0;
    endtask

    // Check the result of the previous step, then drive the next one.
    task automatic step(input bit v, input logic [7:0] a,
                        input logic [7:0] b, input bit l);
        @(negedge clk);
        compare();
        ivalid = v;
        ia     = a;
        ib     = b;
        ilast  = l;
        pend   = 0;
        if (v) begin
            qa.push_back(a);
            qb.push_back(b);
            if (qa.size() == 8 || l) begin
                e_v0    = pack(qa);
                e_v1    = pack(qb);
                e_lanes = 4'(qa.size());
                e_last  = l;
                e_idx   = 16'(vidx);
                e_widx  = 2'(vidx);
                vidx    = l ? 0 : vidx + 1;
                qa.delete();
                qb.delete();
                pend = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic rnd(input bit l);
        step(1'b1, 8'($urandom), 8'($urandom), l);
    endtask

    initial begin
        rst    = 1'b1;
        ivalid = 1'b0;
        ia     = '0;
        ib     = '0;
        ilast  = 1'b0;
        model_clear();
        @(negedge clk);
        compare();
        rst = 1'b0;

        // Full vector a=1..8, b=-1, last on the 8th.
        for (int i = 1; i <= 8; i++)
            step(1'b1, 8'(i), 8'hFF, i == 8);

        // Partial vector right after, staging still holds old lanes.
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(5 + i), 8'd2, i == 2);
        idle(2);

        // Multi-vector dot product of 17 elements.
        for (int i = 0; i < 17; i++) rnd(i == 16);
        idle(1);

        // Two single-element dot products back to back.
        rnd(1'b1);
        rnd(1'b1);

        // 8 elements with random gaps.
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 3)));
            rnd(i == 7);
        end
        idle(1);

        // Reset mid-vector, asserted between clock edges.
        for (int i = 0; i < 4; i++) rnd(1'b0);
        @(negedge clk);
        compare();
        ivalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        compare();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) rnd(i == 7);
        idle(1);

        // Five full vectors in one dot product: wrap on CWIDTH=2.
        for (int i = 0; i < 40; i++) rnd(i == 39);
        idle(1);

        // Random traffic with gaps and dot products of any length.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else rnd($urandom_range(0, 6) == 0);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot8_packer.md
# dot8_packer

Serial-to-parallel front end for the 8-lane dot-product engine. Accepts one signed element pair (a, b) per cycle from the upstream vector source. Packs them into two 8-lane vectors in exactly the format the engine consumes (`vec0`, `vec1`, `ovalid` as the engine's `ivalid`). Handles dot products of any length: a final partial vector is zero-padded, and the vector that ends each dot product is marked.

## Interface
- `IWIDTH`, default 8: element width; signed two's complement.
- `CWIDTH`, default 16: width of the per-dot-product vector index.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ivalid`  in  1  `ia`/`ib`/`ilast` valid this cycle; there is no ready, so every valid element is accepted.
- `ia`  in  IWIDTH  element for `vec0`.
- `ib`  in  IWIDTH  element for `vec1`.
- `ilast`  in  1  this element is the last of the current dot product; ignored when `ivalid`=0.
- `vec0`  out  8*IWIDTH  packed `a` vector; lane k at bits [k*IWIDTH +: IWIDTH].
- `vec1`  out  8*IWIDTH  packed `b` vector; same lane mapping.
- `ovalid`  out  1  single-cycle pulse per emitted vector.
- `olast`  out  1  emitted vector closes a dot product.
- `olanes`  out  4  number of populated lanes, 1..8.
- `ovec_idx`  out  CWIDTH  0-based index of the emitted vector within its dot product.

## Operation
- **Lane counter `cnt` (0..7):** the next element lands in lane `cnt`. Lanes fill in arrival order, lane 0 first (LSB).
- **Staging:** lanes 0..6 are held in staging registers. The element that completes a vector goes straight into the output register together with the staged lanes, so the staging registers are free on the next cycle.
- **Emit condition:** accepted element with `cnt`=7, or accepted element with `ilast`=1.
- **On emit:**
  - Output lanes < populated count take the staged/new values; lanes ≥ count are forced to 0 in both vectors. Stale staging data never appears.
  - `olanes` = `cnt`+1.
  - `olast` = `ilast`.
  - `ovec_idx` = current vector index.
  - `cnt` returns to 0.
- **Vector index:** increments after each emit with `ilast`=0. Returns to 0 after an emit with `ilast`=1. Wraps modulo 2^CWIDTH, with no saturation and no error flag.
- **Both emit conditions at once:** `ilast` on lane 7 is one emit, with `olanes`=8 and `olast`=1.
- **Gaps:** `ivalid`=0 cycles are allowed anywhere. `cnt`, the staging registers and the index hold their values.
- **Outputs between pulses:** `vec0`, `vec1`, `olanes`, `olast` and `ovec_idx` hold their last emitted values. Only `ovalid` drops.
- **No partial-vector timeout:** a partial vector is emitted only on `ilast`.
- **Reset (any time, including mid-vector):** any partially packed vector is discarded and never emitted. After reset, `cnt`=0, the vector index = 0, and all staging registers = 0. Outputs take these reset values:
  - `vec0` = 0, `vec1` = 0
  - `ovalid` = 0, `olast` = 0
  - `olanes` = 0
  - `ovec_idx` = 0

## Timing
- **Latency:** 1 cycle. The emitting element is sampled at edge n; `ovalid` is high between edges n and n+1.
- **Throughput:** full rate. A continuous `ivalid` stream emits one vector every 8 cycles, or sooner when `ilast` arrives. Vectors can be emitted back-to-back in consecutive cycles, e.g. `ilast` on two consecutive elements.
- **Downstream:** `ovalid` is never high for two cycles for the same vector. There is no backpressure; the engine always accepts.
- **End to end:** with the engine's 5-cycle latency, a dot-product result appears 6 cycles after its emitting element. The downstream accumulator sums results up to the `olast` vector.

## Structure
- Shared package `dot8_pkg`:
  - constant `DOT8_LANES` = 8;
  - `olanes` width as a constant;
  - lane-slice helper function mapping lane index to bit offset. The engine and this block share this mapping.
- Single module. No sub-module is warranted: the datapath is staging registers plus a masked output register, and the control is one counter.

## Test plan
- **Full vector:** 8 consecutive elements a=1..8, b=−1, `ilast` on the 8th → one `ovalid` pulse the cycle after the 8th element; `vec0` lanes 0..7 = 1..8, `vec1` lanes all 0xFF; `olanes`=8, `olast`=1, `ovec_idx`=0.
- **Partial vector:** 3 elements a=5,6,7, b=2 with `ilast` on the 3rd → lanes 3..7 zero in both vectors, `olanes`=3, `olast`=1. Run this immediately after a full vector whose staging held nonzero lanes, to prove no stale data leaks.
- **Multi-vector dot product:** 17 elements, `ilast` on the 17th → pulses with `ovec_idx` 0,1,2; `olanes` 8,8,1; `olast` only on the third.
- **Back-to-back and gaps:** `ilast` on each of two consecutive cycles → `ovalid` high on two consecutive cycles, each with `olanes`=1 and `ovec_idx`=0. Then random `ivalid` gaps inside an 8-element vector → a single emit whose contents match gap-free packing.
- **Reset mid-vector:** 4 elements, assert `rst` asynchronously between clock edges → outputs go to 0 immediately. Then 8 fresh elements → first pulse contains only the fresh elements, with `ovec_idx`=0.
- **Index wrap:** `CWIDTH`=2, 5 full vectors with `ilast` only on the 5th → `ovec_idx` sequence 0,1,2,3,0.
